// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display blocks.
// Provides: MAX_DIGITS, SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH,
//           digit_to_seg() (values 10..15 map to blank) and pow10().
// All segment codes are {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  // Map one BCD digit to its segment pattern; non-decimal codes show blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (d == 4'(i)) s = SEG_DIGIT[i];
    end
    return s;
  endfunction

  // Elaboration-time 10^n.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One add-3/shift step per cycle, VALUE_W steps per conversion; the first
// step is taken on the start edge so the result is ready VALUE_W-1 edges later.
// Ports: clk, rst (sync, active-high), start (capture din), din (binary),
//        done (high in the cycle the final bcd is valid), bcd (NUM_DIGITS
//        nibbles, digit 0 in the low nibble), ovf (din >= 10^NUM_DIGITS,
//        captured with din).
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned VALUE_W    = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      din,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
  localparam longint unsigned LIMIT = pow10(NUM_DIGITS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [VALUE_W-1:0] sh, sh_nxt;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               done_nxt, ovf_nxt;

  // One double-dabble step: correct nibbles >= 5, then shift in the next bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                               input logic bit_in);
    logic [BCD_W-1:0] a;
    a = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[BCD_W-2:0], bit_in};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      bcd   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      bcd   <= bcd_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    bcd_nxt   = bcd;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          bcd_nxt   = dd_step('0, din[VALUE_W-1]);
          sh_nxt    = din << 1;
          cnt_nxt   = CNT_W'(1);
          ovf_nxt   = (64'(din) >= LIMIT);
          done_nxt  = (VALUE_W == 1);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (done) begin
          state_nxt = IDLE;
        end else begin
          bcd_nxt  = dd_step(bcd, sh[VALUE_W-1]);
          sh_nxt   = sh << 1;
          cnt_nxt  = cnt + CNT_W'(1);
          done_nxt = (cnt == CNT_W'(VALUE_W - 1));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/multi_digit_display.sv
// Multiplexed seven-segment driver: load/busy capture of a binary value,
// sequential BCD conversion, and a scanned common-anode display.
// Ports: clk, rst (sync, active-high), value/load (capture when busy=0),
//        busy, overflow (shown as dashes), AN (active-low digit enables),
//        SEG ({a..g}, active-low).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the
// most significant nonzero digit (digit 0 always shown, not while overflow).
module multi_digit_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned VALUE_W     = 14,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [6:0]            SEG
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [PRE_W-1:0]           pre;
  logic [IDX_W-1:0]           idx;
  logic                       conv_done, conv_ovf;
  logic [4*NUM_DIGITS-1:0]    conv_bcd;
  logic                       start_c, blank_c;
  logic [6:0]                 seg_c;

  assign start_c = load & ~busy;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .din   (value),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Leading-zero blank for the digit currently selected by idx
  always_comb begin
    blank_c = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != '0) begin
      blank_c = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IDX_W'(i) >= idx && digits[i] != 4'd0) blank_c = 1'b0;
      end
    end
`endif
  end

  // Segment pattern for the selected digit; overflow overrides everything
  always_comb begin
    seg_c = digit_to_seg(digits[idx]);
    if (overflow)     seg_c = SEG_DASH;
    else if (blank_c) seg_c = SEG_BLANK;
  end

  // Capture/commit, prescaler, scan index and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      overflow <= 1'b0;
      digits   <= '0;
      pre      <= '0;
      idx      <= '0;
      AN       <= '1;
      SEG      <= SEG_BLANK;
    end else begin
      // Display registers change only at commit, so partial results never show
      if (start_c) begin
        busy <= 1'b1;
      end else if (conv_done) begin
        busy     <= 1'b0;
        digits   <= conv_bcd;
        overflow <= conv_ovf;
      end

      if (pre == PRE_W'(REFRESH_DIV - 1)) begin
        pre <= '0;
        if (idx == IDX_W'(NUM_DIGITS - 1)) idx <= '0;
        else                               idx <= idx + IDX_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end

      AN  <= ~(NUM_DIGITS'(1) << idx);
      SEG <= seg_c;
    end
  end

endmodule

// File: tb/tb_multi_digit_display.sv
// Self-checking bench for multi_digit_display (4 digits, 14-bit value,
// refresh divider 4): behavioural model compared every cycle, plus
// literal expectations for the directed scenarios.
module tb_multi_digit_display;

  localparam int ND = 4;
  localparam int VW = 14;
  localparam int RD = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit         LZB     = 1'b1;
  localparam logic [6:0] HI_ZERO = 7'b1111111;
`else
  localparam bit         LZB     = 1'b0;
  localparam logic [6:0] HI_ZERO = 7'b0000001;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [VW-1:0] value = '0;
  logic          busy, overflow;
  logic [ND-1:0] AN;
  logic [6:0]    SEG;

  int errors = 0;
  int checks = 0;

  multi_digit_display #(
    .NUM_DIGITS  (ND),
    .VALUE_W     (VW),
    .REFRESH_DIV (RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .overflow (overflow),
    .AN       (AN),
    .SEG      (SEG)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int p10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Behavioural model: what the outputs must be after each rising edge
  int         m_val, m_pend, m_rem, m_t, m_idx;
  bit         m_busy, m_ovf, m_valid = 1'b0;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_ovf = 1'b0; m_val = 0; m_rem = 0; m_t = 0;
      m_an = 4'hF; m_seg = 7'h7F; m_valid = 1'b1;
    end else begin
      m_idx = (m_t / RD) % ND;
      m_an  = ~(4'b0001 << m_idx);
      if (m_ovf)                                        m_seg = 7'b1111110;
      else if (LZB && m_idx > 0 && m_val < p10(m_idx))  m_seg = 7'b1111111;
      else                                              m_seg = seg_of((m_val / p10(m_idx)) % 10);
      m_t++;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_val  = m_pend;
          m_ovf  = (m_pend >= p10(ND));
        end
      end else if (load) begin
        m_pend = int'(value);
        m_busy = 1'b1;
        m_rem  = VW;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("AN", 32'(AN), 32'(m_an));
      chk("SEG", 32'(SEG), 32'(m_seg));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: busy still %b after 100 cycles", busy);
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    value = VW'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Watch n cycles: whenever an_e is active, SEG must equal seg_e; it must appear
  task automatic scan_check(input string name, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input int n);
    bit seen = 1'b0;
    bit bad = 1'b0;
    logic [6:0] got = seg_e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (AN == an_e) begin
        seen = 1'b1;
        if (SEG !== seg_e) begin bad = 1'b1; got = SEG; end
      end
    end
    checks++;
    if (!seen || bad) begin
      errors++;
      $display("FAIL %s: AN=%b seen=%0d SEG=%b expected %b", name, an_e, seen, got, seg_e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_seg", 32'(SEG), 32'h7F);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", 32'(AN), 32'b1110);
    chk("first_seg", 32'(SEG), 32'b0000001);

    // 1234: busy length and full scan
    do_load(1234);
    cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len", 32'(cnt), 32'd14);
    scan_check("d0_1234", 4'b1110, 7'b1001100, 16);
    scan_check("d1_1234", 4'b1101, 7'b0000110, 16);
    scan_check("d2_1234", 4'b1011, 7'b0010010, 16);
    scan_check("d3_1234", 4'b0111, 7'b1001111, 16);

    // Overflow then recovery
    do_load(10000);
    wait_idle();
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 32'h1);
    scan_check("dash_d0", 4'b1110, 7'b1111110, 16);
    scan_check("dash_d3", 4'b0111, 7'b1111110, 16);
    do_load(9999);
    wait_idle();
    @(negedge clk);
    chk("ovf_clr", 32'(overflow), 32'h0);
    scan_check("nine_d0", 4'b1110, 7'b0000100, 16);
    scan_check("nine_d3", 4'b0111, 7'b0000100, 16);

    // Small values and leading zeros
    do_load(7);
    wait_idle();
    scan_check("seven_d0", 4'b1110, 7'b0001111, 16);
    scan_check("seven_d1", 4'b1101, HI_ZERO, 16);
    scan_check("seven_d3", 4'b0111, HI_ZERO, 16);
    do_load(0);
    wait_idle();
    scan_check("zero_d0", 4'b1110, 7'b0000001, 16);
    scan_check("zero_d2", 4'b1011, HI_ZERO, 16);

    // Load during busy is ignored
    do_load(42);
    repeat (4) @(negedge clk);
    value = VW'(99);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_idle();
    scan_check("fortytwo_d0", 4'b1110, 7'b0010010, 16);
    scan_check("fortytwo_d1", 4'b1101, 7'b1001100, 16);

    // Back-to-back: load on the first busy=0 cycle is accepted
    do_load(100);
    wait_idle();
    value = VW'(321);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    chk("b2b_busy", 32'(busy), 32'h1);
    wait_idle();
    scan_check("b2b_d2", 4'b1011, 7'b0000110, 16);

    // Reset mid-conversion
    do_load(5555);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", 32'(AN), 32'hF);
    chk("midrst_seg", 32'(SEG), 32'h7F);
    chk("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    scan_check("midrst_d0", 4'b1110, 7'b0000001, 16);
    scan_check("midrst_d1", 4'b1101, HI_ZERO, 16);
    chk("midrst_idle", 32'(busy), 32'h0);

    // Randomized traffic, including loads while busy and rare resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 7) == 0);
      value = ($urandom_range(0, 1) == 1) ? VW'($urandom_range(0, 120)) : VW'($urandom);
      rst   = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_digit_display.md
# multi_digit_display

Parametrised multiplexed seven-segment driver and next generation of the fixed three-digit display driver. It accepts a binary value through a load/busy handshake and converts it to BCD with a sequential double-dabble converter. It then time-multiplexes NUM_DIGITS common-anode digits at a programmable refresh rate. It sits between the classifier result path and the board's AN/SEG pins.

## Interface
- NUM_DIGITS, 4: digits driven; legal range 1..8.
- VALUE_W, 14: width of the binary input; legal range 1..27.
- REFRESH_DIV, 100000: clk cycles each digit stays lit; minimum 1.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous and active-high.
- value  input  VALUE_W  unsigned binary number to display.
- load  input  1  request to capture value; accepted only when busy=0.
- busy  output  1  conversion in progress; load is ignored while high.
- overflow  output  1  the last accepted value was ≥ 10^NUM_DIGITS.
- AN  output  NUM_DIGITS  digit enables; active-low, one-hot-low while scanning.
- SEG  output  7  segments {a,b,c,d,e,f,g} with a as the MSB; active-low.

## Operation
- Handshake: load=1 with busy=0 at edge N captures value. busy=1 from N+1 through N+VALUE_W.
- Converter: performs one add-3/shift step per cycle, VALUE_W steps in total, on a BCD register 4*NUM_DIGITS bits wide.
- Commit: at edge N+VALUE_W the display digit registers and overflow are updated together, and busy returns to 0.
- Timing of the next load: busy=0 from cycle N+VALUE_W+1, so a back-to-back load is accepted there.
- Display holds the previous result for the whole conversion, so no partially converted digits ever appear.
- overflow is set when the captured value ≥ 10^NUM_DIGITS, computed from a constant compare at capture. While overflow=1, every digit shows a dash (g only lit, SEG=7'b1111110).
- Scan: a prescaler counts 0..REFRESH_DIV-1. At its terminal count the digit index advances, wrapping from NUM_DIGITS-1 to 0. With REFRESH_DIV=1 the index advances every cycle.
- Segment codes, 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. Blank is 1111111.
- A digit register value of 10..15 is unreachable; if one occurs, that digit shows blank.

## Timing
- Reset values: AN all ones, SEG=7'b1111111, busy=0, overflow=0, digit registers 0, index 0, prescaler 0, converter idle.
- AN and SEG are registered: they reflect the index and digit registers of the previous cycle.
  - In the first cycle after rst falls, AN=~1 (digit 0 enabled) and SEG shows '0'.
- Digit index i drives AN bit i low. Digit 0 is the least significant digit.
- Conversion latency: VALUE_W cycles from the accept edge to the commit edge. The scan is never stalled by a conversion.
- rst asserted mid-conversion aborts it. The result is discarded and all registers take their reset values.
- load and rst in the same cycle: rst wins.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Every digit above the most significant nonzero digit shows blank.
  - Digit 0 is never blanked, so value 0 shows a single '0'.
  - Blanking does not apply while overflow=1.
- LEADING_ZERO_BLANK_EN undefined: all NUM_DIGITS digits show, including leading zeros.

## Structure
- Package seg7_pkg holds the following, shared with other display blocks:
  - SEG_DIGIT[0:9] code constants, SEG_BLANK and SEG_DASH.
  - A digit-to-segment function.
  - The MAX_DIGITS=8 limit.
- Sub-module bin2bcd_seq, the sequential double-dabble converter:
  - Parameters VALUE_W and NUM_DIGITS.
  - Ports start, din, done, bcd, ovf.
- The top level holds the capture/commit logic, prescaler, scan index and output registers.

## Test plan
- All tests use NUM_DIGITS=4, VALUE_W=14, REFRESH_DIV=4.
- Load 1234 → busy high exactly 14 cycles. Scan then shows AN=1110 SEG=1001100, AN=1101 SEG=0000110, AN=1011 SEG=0010010, AN=0111 SEG=1001111, each for 4 cycles, then repeats.
- Load 10000 → overflow=1 and all four digits show SEG=1111110. A following load of 9999 clears overflow and shows 9s on all digits.
- Load 7 → digit 0 shows 0001111. Digits 1..3 show 1111111 with LEADING_ZERO_BLANK_EN and 0000001 without it. Load 0 → only digit 0 shows 0000001 when blanking is enabled.
- Load 42, then pulse load with 99 on cycle 5 of busy → 99 is ignored and 42 is displayed. A load on the first cycle with busy=0 is accepted.
- Load 5555, assert rst on cycle 7 of busy → outputs take their reset values. The display then shows 0000 (blanked to '0' when LEADING_ZERO_BLANK_EN is defined) and busy=0.
